// File: rtl/trigger_cmd_sequencer.sv
// Host-side command initiator for trigger_system: assembles 5-byte SPI frames
// and issues each command bracketed by HALT on the trigger command bus.
module trigger_cmd_sequencer #(
    parameter int NUM_STAGES = 4,
    parameter int CMD_HOLD   = 1,
    parameter int TIMEOUT    = 255
) (
    input  logic                  inclk,
    input  logic                  reset_n,
    input  logic [7:0]            byte_data,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic [7:0]            command,
    output logic [23:0]           config_out,
    output logic [NUM_STAGES-1:0] stage_we,
    input  logic                  triggered,
    output logic                  busy,
    output logic                  fired,
    output logic                  err,
    output logic [2:0]            state_dbg
);

    // Handshake: a byte moves only on an inclk rising edge where byte_valid and
    // byte_ready are both high; byte_valid while byte_ready is low is ignored.

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_COLLECT  = 3'd1,
        S_VALIDATE = 3'd2,
        S_SETUP    = 3'd3,
        S_ISSUE    = 3'd4,
        S_RELEASE  = 3'd5
    } state_t;

    localparam logic [7:0]  CMD_RUN   = 8'd0;
    localparam logic [7:0]  CMD_HALT  = 8'd1;
    localparam logic [7:0]  CMD_MAX   = 8'd8;
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);
    localparam logic [3:0]  HOLD_LAST = 4'(CMD_HOLD);

    state_t      state;
    logic [2:0]  byte_idx;
    logic [15:0] timeout_cnt;
    logic [3:0]  hold_cnt;
    logic [7:0]  frame_code;
    logic [7:0]  frame_mask;
    logic [23:0] frame_cfg;

    logic        xfer;
    logic [7:0]  mask_upper;
    logic        code_uses_mask;
    logic        frame_reject;

    assign xfer      = byte_valid && byte_ready;
    assign state_dbg = state;

    // B0 and B1 are already stored when B4 arrives, so the verdict is ready at
    // the B4 edge and err can line up with the VALIDATE cycle.
    assign mask_upper     = frame_mask >> NUM_STAGES;
    assign code_uses_mask = (frame_code >= 8'd2) && (frame_code <= CMD_MAX);
    assign frame_reject   = (frame_code > CMD_MAX) ||
                            (code_uses_mask && ((mask_upper != 8'd0) ||
                                                (frame_mask[NUM_STAGES-1:0] == '0)));

    always_ff @(posedge inclk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            byte_idx    <= 3'd0;
            timeout_cnt <= 16'd0;
            hold_cnt    <= 4'd0;
            frame_code  <= 8'd0;
            frame_mask  <= 8'd0;
            frame_cfg   <= 24'd0;
            command     <= CMD_HALT;
            config_out  <= 24'd0;
            stage_we    <= '0;
            byte_ready  <= 1'b1;
            busy        <= 1'b0;
            fired       <= 1'b0;
            err         <= 1'b0;
        end else begin
            err <= 1'b0;
            if (triggered && (command == CMD_RUN)) begin
                fired <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    timeout_cnt <= 16'd0;
                    if (xfer) begin
                        frame_code <= byte_data;
                        byte_idx   <= 3'd1;
                        busy       <= 1'b1;
                        state      <= S_COLLECT;
                    end
                end

                S_COLLECT: begin
                    if (xfer) begin
                        timeout_cnt <= 16'd0;
                        case (byte_idx)
                            3'd1:    frame_mask        <= byte_data;
                            3'd2:    frame_cfg[23:16]  <= byte_data;
                            3'd3:    frame_cfg[15:8]   <= byte_data;
                            default: frame_cfg[7:0]    <= byte_data;
                        endcase
                        if (byte_idx == 3'd4) begin
                            byte_idx   <= 3'd0;
                            byte_ready <= 1'b0;
                            err        <= frame_reject;
                            state      <= S_VALIDATE;
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                        end
                    end else if (timeout_cnt == TMO_LAST) begin
                        // Stalled host: drop the partial frame, bus untouched.
                        err         <= 1'b1;
                        busy        <= 1'b0;
                        byte_idx    <= 3'd0;
                        timeout_cnt <= 16'd0;
                        state       <= S_IDLE;
                    end else begin
                        timeout_cnt <= timeout_cnt + 16'd1;
                    end
                end

                S_VALIDATE: begin
                    if (frame_reject) begin
                        byte_ready <= 1'b1;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end else begin
                        command <= CMD_HALT;
                        fired   <= 1'b0;
                        if (code_uses_mask) begin
                            config_out <= frame_cfg;
                            stage_we   <= frame_mask[NUM_STAGES-1:0];
                        end
                        state <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    command  <= frame_code;
                    hold_cnt <= 4'd1;
                    state    <= S_ISSUE;
                end

                S_ISSUE: begin
                    if (hold_cnt == HOLD_LAST) begin
                        // RUN stays on the bus until the next accepted frame.
                        command <= (frame_code == CMD_RUN) ? CMD_RUN : CMD_HALT;
                        state   <= S_RELEASE;
                    end else begin
                        hold_cnt <= hold_cnt + 4'd1;
                    end
                end

                S_RELEASE: begin
                    byte_ready <= 1'b1;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end

                default: begin
                    byte_ready <= 1'b1;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trigger_cmd_sequencer.sv
// Randomized scoreboard bench for trigger_cmd_sequencer: a frame-level model
// predicts every change of the bus/status tuple and a monitor checks them in order.
module tb_trigger_cmd_sequencer;

    localparam int NS   = 4;
    localparam int HOLD = 1;
    localparam int TMO  = 8;
    localparam int W    = 1 + 1 + 8 + 24 + NS;

    logic          inclk = 1'b0;
    logic          reset_n = 1'b1;
    logic [7:0]    byte_data = 8'd0;
    logic          byte_valid = 1'b0;
    logic          byte_ready;
    logic [7:0]    command;
    logic [23:0]   config_out;
    logic [NS-1:0] stage_we;
    logic          triggered = 1'b0;
    logic          busy;
    logic          fired;
    logic          err;
    logic [2:0]    state_dbg;

    always #5 inclk = ~inclk;

    trigger_cmd_sequencer #(
        .NUM_STAGES (NS),
        .CMD_HOLD   (HOLD),
        .TIMEOUT    (TMO)
    ) dut (
        .inclk      (inclk),
        .reset_n    (reset_n),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .command    (command),
        .config_out (config_out),
        .stage_we   (stage_we),
        .triggered  (triggered),
        .busy       (busy),
        .fired      (fired),
        .err        (err),
        .state_dbg  (state_dbg)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [W-1:0] exp_q[$];
    logic         mon_en = 1'b0;
    logic [W-1:0] mon_prev = '0;

    // Reference model: what the bus looks like between frames.
    logic [7:0]    m_cmd;
    logic [23:0]   m_cfg;
    logic [NS-1:0] m_we;
    logic          m_fired;
    logic [W-1:0]  m_last;

    function automatic logic [W-1:0] pack_t(input logic f, input logic e, input logic [7:0] c,
                                            input logic [23:0] cf, input logic [NS-1:0] w);
        return {f, e, c, cf, w};
    endfunction

    task automatic push_state(input logic e);
        logic [W-1:0] t;
        t = pack_t(m_fired, e, m_cmd, m_cfg, m_we);
        if (t !== m_last) begin
            exp_q.push_back(t);
            m_last = t;
        end
    endtask

    task automatic model_err();
        push_state(1'b1);
        push_state(1'b0);
    endtask

    task automatic model_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                               input logic [7:0] b3, input logic [7:0] b4);
        logic       bad;
        logic [7:0] hi;
        hi  = b1 >> NS;
        bad = (b0 > 8'd8) || ((b0 >= 8'd2) && ((hi != 8'd0) || (b1[NS-1:0] == '0)));
        if (bad) begin
            model_err();
        end else begin
            m_fired = 1'b0;
            m_cmd   = 8'd1;
            if (b0 >= 8'd2) begin
                m_cfg = {b2, b3, b4};
                m_we  = b1[NS-1:0];
            end
            push_state(1'b0);
            m_cmd = b0;
            push_state(1'b0);
            m_cmd = (b0 == 8'd0) ? 8'd0 : 8'd1;
            push_state(1'b0);
        end
    endtask

    always @(negedge inclk) begin : monitor
        logic [W-1:0] cur;
        logic [W-1:0] want;
        cur = {fired, err, command, config_out, stage_we};
        if (mon_en && (cur !== mon_prev)) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL bus_event: got %h, nothing expected", cur);
            end else begin
                want = exp_q.pop_front();
                if (cur !== want) begin
                    miscompares++;
                    $display("FAIL bus_event: got %h expected %h", cur, want);
                end
            end
        end
        mon_prev = cur;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge inclk);
    endtask

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        byte_data  = b;
        byte_valid = 1'b1;
        while (!byte_ready && guard < 60) begin
            @(negedge inclk);
            guard++;
        end
        if (guard >= 60) begin
            vectors++;
            miscompares++;
            $display("FAIL byte_ready_wait: got 0 expected 1 within 60 cycles");
        end
        @(negedge inclk);
        byte_valid = 1'b0;
    endtask

    task automatic send_raw(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4, input int maxgap);
        logic [7:0] fb[5];
        fb[0] = b0; fb[1] = b1; fb[2] = b2; fb[3] = b3; fb[4] = b4;
        for (int i = 0; i < 5; i++) begin
            if (i > 0 && maxgap > 0) tick(int'($urandom_range(0, maxgap)));
            send_byte(fb[i]);
        end
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input logic [7:0] b4, input int maxgap);
        model_frame(b0, b1, b2, b3, b4);
        send_raw(b0, b1, b2, b3, b4, maxgap);
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (!(byte_ready && !busy) && guard < 40) begin
            @(negedge inclk);
            guard++;
        end
        if (guard >= 40) begin
            vectors++;
            miscompares++;
            $display("FAIL idle_wait: byte_ready=%0b busy=%0b after 40 cycles", byte_ready, busy);
        end
    endtask

    task automatic pulse_trigger();
        if (m_cmd == 8'd0) begin
            m_fired = 1'b1;
            push_state(1'b0);
        end
        triggered = 1'b1;
        tick(1);
        triggered = 1'b0;
        tick(1);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [7:0] b0, b1, b2, b3, b4;
        int         kind, nb;

        m_cmd = 8'd1; m_cfg = 24'd0; m_we = '0; m_fired = 1'b0;
        m_last = pack_t(1'b0, 1'b0, 8'd1, 24'd0, '0);

        #2 reset_n = 1'b0;
        tick(3);
        chk("rst_command", 32'(command), 32'd1);
        chk("rst_config", 32'(config_out), 32'd0);
        chk("rst_stage_we", 32'(stage_we), 32'd0);
        chk("rst_byte_ready", 32'(byte_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fired", 32'(fired), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        reset_n = 1'b1;
        tick(2);
        mon_en = 1'b1;

        // Cycle-exact accepted frame, with a byte offered while not ready.
        send_frame(8'h02, 8'h02, 8'h00, 8'h02, 8'h00, 0);
        chk("n1_busy", 32'(busy), 32'd1);
        chk("n1_byte_ready", 32'(byte_ready), 32'd0);
        chk("n1_err", 32'(err), 32'd0);
        byte_data = 8'h09; byte_valid = 1'b1;
        tick(1);
        chk("n2_stage_we", 32'(stage_we), 32'h2);
        chk("n2_config", 32'(config_out), 32'h000200);
        chk("n2_command", 32'(command), 32'd1);
        tick(1);
        chk("n3_command", 32'(command), 32'd2);
        tick(1);
        chk("n4_command", 32'(command), 32'd1);
        chk("n4_byte_ready", 32'(byte_ready), 32'd0);
        byte_valid = 1'b0;
        tick(1);
        chk("n5_byte_ready", 32'(byte_ready), 32'd1);
        chk("n5_busy", 32'(busy), 32'd0);

        // Rejected frames: bad code, then mask zero for a staged command.
        send_frame(8'h09, 8'h01, 8'haa, 8'hbb, 8'hcc, 0);
        chk("rej9_err", 32'(err), 32'd1);
        chk("rej9_byte_ready_n1", 32'(byte_ready), 32'd0);
        tick(1);
        chk("rej9_byte_ready_n2", 32'(byte_ready), 32'd1);
        chk("rej9_err_n2", 32'(err), 32'd0);
        chk("rej9_stage_we", 32'(stage_we), 32'h2);
        send_frame(8'h05, 8'h00, 8'h11, 8'h22, 8'h33, 0);
        chk("rej5_err", 32'(err), 32'd1);
        tick(1);
        chk("rej5_byte_ready", 32'(byte_ready), 32'd1);
        chk("rej5_config", 32'(config_out), 32'h000200);

        // RUN, trigger, then HALT clears fired.
        send_frame(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1);
        wait_idle();
        chk("run_command", 32'(command), 32'd0);
        pulse_trigger();
        tick(3);
        chk("run_fired_sticky", 32'(fired), 32'd1);
        send_frame(8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 1);
        wait_idle();
        chk("halt_command", 32'(command), 32'd1);
        chk("halt_fired", 32'(fired), 32'd0);

        // Timeout after three bytes, then a clean frame from B0.
        model_err();
        send_byte(8'h03); send_byte(8'h01); send_byte(8'h55);
        tick(TMO - 1);
        chk("tmo_err_early", 32'(err), 32'd0);
        tick(1);
        chk("tmo_err", 32'(err), 32'd1);
        chk("tmo_busy", 32'(busy), 32'd0);
        tick(1);
        chk("tmo_err_fall", 32'(err), 32'd0);
        send_frame(8'h03, 8'h04, 8'h12, 8'h34, 8'h56, 2);
        wait_idle();
        chk("tmo_next_we", 32'(stage_we), 32'h4);
        chk("tmo_next_cfg", 32'(config_out), 32'h123456);

        // Full configuration sequence ending in RUN.
        send_frame(8'h03, 8'h0f, 8'h00, 8'h00, 8'h5a, 1); wait_idle();
        send_frame(8'h04, 8'h0f, 8'h00, 8'h00, 8'hff, 1); wait_idle();
        send_frame(8'h05, 8'h0f, 8'h00, 8'h00, 8'h0f, 1); wait_idle();
        send_frame(8'h06, 8'h0f, 8'h01, 8'h02, 8'h03, 1); wait_idle();
        send_frame(8'h02, 8'h02, 8'h00, 8'h00, 8'h77, 1); wait_idle();
        send_frame(8'h04, 8'h02, 8'h00, 8'h00, 8'hf0, 1); wait_idle();
        send_frame(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1); wait_idle();
        chk("seq_command", 32'(command), 32'd0);
        chk("seq_stage_we", 32'(stage_we), 32'h2);
        chk("seq_config", 32'(config_out), 32'h0000f0);

        // Randomized frames.
        for (int n = 0; n < 150; n++) begin
            kind = int'($urandom_range(0, 9));
            b2 = 8'($urandom_range(0, 255));
            b3 = 8'($urandom_range(0, 255));
            b4 = 8'($urandom_range(0, 255));
            if (kind < 6) begin
                b0 = 8'($urandom_range(2, 8));
                b1 = 8'($urandom_range(1, 15));
            end else if (kind < 8) begin
                b0 = 8'($urandom_range(0, 1));
                b1 = 8'($urandom_range(0, 15));
            end else if (kind == 8) begin
                case ($urandom_range(0, 2))
                    0: begin b0 = 8'($urandom_range(9, 255)); b1 = 8'($urandom_range(0, 255)); end
                    1: begin b0 = 8'($urandom_range(2, 8));   b1 = 8'($urandom_range(16, 255)); end
                    default: begin b0 = 8'($urandom_range(2, 8)); b1 = 8'd0; end
                endcase
            end else begin
                b0 = 8'($urandom_range(0, 255));
                b1 = 8'($urandom_range(0, 255));
            end

            if (kind == 9) begin
                nb = int'($urandom_range(1, 4));
                model_err();
                send_byte(b0);
                if (nb > 1) send_byte(b1);
                if (nb > 2) send_byte(b2);
                if (nb > 3) send_byte(b3);
                tick(TMO + 1);
            end else begin
                send_frame(b0, b1, b2, b3, b4, 3);
            end
            wait_idle();
            tick(int'($urandom_range(0, 2)));
            if ($urandom_range(0, 2) == 0) pulse_trigger();
        end

        tick(6);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset while the command is on the bus.
        mon_en = 1'b0;
        send_raw(8'h02, 8'h01, 8'hab, 8'hcd, 8'hef, 0);
        tick(2);
        chk("mid_issue_command", 32'(command), 32'd2);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_command", 32'(command), 32'd1);
        chk("async_rst_config", 32'(config_out), 32'd0);
        chk("async_rst_stage_we", 32'(stage_we), 32'd0);
        chk("async_rst_byte_ready", 32'(byte_ready), 32'd1);
        chk("async_rst_busy", 32'(busy), 32'd0);
        @(negedge inclk);
        reset_n = 1'b1;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
